prog_sequencer: RTL and testbench
=================================

# prog_sequencer

Program sequencer that sits directly upstream of the 9-bit processor and drives its `DIN` and `Run` inputs. It holds a small loadable instruction memory and fetches instruction words in order. For each instruction it pulses `Run`, supplies the immediate word for `mvi`, waits for the processor's `Done`, and then advances the program counter. A watchdog flags an error if the processor never answers.

## Interface
Parameters:
- `ADDR_W`, default 5 — instruction memory address width; depth is 2^ADDR_W words.
- `TIMEOUT`, default 15 — maximum number of WAIT cycles without `Done` before an error is declared; must be ≥ 4.

Ports:
- `Clock` — input, 1 bit — single clock; all state changes on the rising edge.
- `Reset` — input, 1 bit — synchronous, active-high reset.
- `Start` — input, 1 bit — begin executing at address 0; sampled only in IDLE.
- `ProgLen` — input, ADDR_W+1 bits — number of words in the program.
- `LoadEn` — input, 1 bit — memory write enable.
- `LoadAddr` — input, ADDR_W bits — memory write address.
- `LoadData` — input, 9 bits — memory write data.
- `Done` — input, 1 bit — from the processor.
- `DIN` — output, 9 bits — to the processor's `DIN`.
- `Run` — output, 1 bit — to the processor's `Run`.
- `PC` — output, ADDR_W bits — current instruction address.
- `Busy` — output, 1 bit — high when state is not IDLE.
- `Finished` — output, 1 bit — one-cycle pulse at program end.
- `Error` — output, 1 bit — sticky watchdog flag.

## Operation
- Memory is an array of 2^ADDR_W × 9-bit words with asynchronous read.
  - A write occurs on an edge with `LoadEn`=1, but only while in IDLE; writes are ignored otherwise.
  - `Reset` does not clear memory.
- Instruction format: opcode is `IR[8:6]`. Opcode 3'b001 is `mvi`, a 2-word instruction whose next word is the immediate. All other opcodes are 1-word.
- IDLE: `Run`=0, `DIN`=0.
  - `Start`=1 with `ProgLen`≠0: PC←0, go to ISSUE.
  - `Start`=1 with `ProgLen`=0: `Finished` pulses and the state stays IDLE.
- ISSUE (exactly 1 cycle):
  - `Run`=1 and `DIN`=mem[PC].
  - Latch `IsMvi`=(mem[PC][8:6]==3'b001), clear the watchdog, go to WAIT.
- WAIT:
  - `Run`=0. `DIN`=mem[(PC+1) mod 2^ADDR_W] if `IsMvi`, else mem[PC].
  - The watchdog increments each WAIT cycle.
  - On `Done`=1: next = PC + (`IsMvi` ? 2 : 1), computed ADDR_W+1 wide.
    - If next ≥ `ProgLen`: go to IDLE, `Finished`=1 for the following cycle, and PC keeps its last value.
    - Otherwise: PC←next[ADDR_W-1:0], go to ISSUE.
  - If the watchdog reaches `TIMEOUT` without `Done`: go to ERR.
- ERR: `Run`=0, `DIN`=0, `Error`=1, `Busy`=1. Only `Reset` leaves ERR; `Start` is ignored.
- `Done` is ignored outside WAIT.
- `Start` is ignored outside IDLE.
- A `mvi` placed as the last word (PC+1 == `ProgLen`) still presents the wrapped immediate address and completes normally.
- `Run` and `Busy` are decoded from the state register only, with no input-to-output combinational path. `DIN` depends only on the state, PC, `IsMvi` and the memory.

## Timing
- Reset values: state IDLE, PC=0, `IsMvi`=0, watchdog=0, `Run`=0, `DIN`=0, `Busy`=0, `Finished`=0, `Error`=0.
- Reset asserted mid-program returns to IDLE on the next edge, and `Run` is low from that edge.
- Start latency: `Start` sampled at edge n puts ISSUE in cycle n+1 (`Run`=1).
- `Run` is high for exactly one cycle per instruction.
- The immediate word appears on `DIN` from the cycle after `Run`.
- `Done` in cycle k: the next ISSUE is in cycle k+1, or `Finished` is in cycle k+1.
- Watchdog: the first WAIT cycle counts as 1. If `Done` is still absent in WAIT cycle `TIMEOUT`, ERR is entered on the following edge. `Done` arriving in WAIT cycle `TIMEOUT` is still accepted.
- Loading while not IDLE has no effect on memory contents.

## Test plan
- Load mem[0]=9'h040 and mem[1]=9'd5, `ProgLen`=2, pulse `Start`, and model `Done` 2 cycles after `Run`.
  - Required: `Run` one cycle with `DIN`=9'h040, then `DIN`=9'd5, then `Finished` one cycle and `Busy`=0.
- Program 9'h081, 9'h0C2, 9'h008 (three 1-word instructions), `ProgLen`=3, `Done` 3 cycles after each `Run`.
  - Required: exactly 3 `Run` pulses with PC=0,1,2 and back-to-back ISSUE the cycle after each `Done`.
- Hold `Done`=0 with `TIMEOUT`=15.
  - Required: `Error`=1 after 15 WAIT cycles, `Run` stays 0, `Start` is ignored, `Reset` clears `Error`.
- Assert `Reset` during WAIT of the 2nd instruction.
  - Required: IDLE and PC=0 next cycle. Re-`Start` replays the program from address 0 with memory intact.
- Attempt `LoadEn` writes of 9'h1FF while `Busy`.
  - Required: memory is unchanged. `Start` with `ProgLen`=0 gives `Finished` with no `Run`.
- `mvi` 9'h040 at the last address (PC=`ProgLen`-1=31).
  - Required: `DIN`=mem[0] during WAIT, and `Finished` after `Done`.

Source files
------------

// File: rtl/prog_sequencer.sv
// Program sequencer: fetches 9-bit instruction words from a loadable memory,
// pulses Run per instruction, supplies mvi immediates and waits for Done.
module prog_sequencer #(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 15
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W:0]   ProgLen,
  input  logic              LoadEn,
  input  logic [ADDR_W-1:0] LoadAddr,
  input  logic [8:0]        LoadData,
  input  logic              Done,
  output logic [8:0]        DIN,
  output logic              Run,
  output logic [ADDR_W-1:0] PC,
  output logic              Busy,
  output logic              Finished,
  output logic              Error,
  output logic [1:0]        StateDbg
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ERR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              is_mvi_q, is_mvi_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              finished_q, finished_d;

  logic [8:0]        mem_q [2**ADDR_W];
  logic [8:0]        ir;
  logic [ADDR_W-1:0] imm_addr;
  logic [ADDR_W:0]   next_pc;
  logic [1:0]        step;
  logic [WD_W-1:0]   wdog_inc;

  // Memory is writable only in IDLE and is deliberately left out of reset.
  always_ff @(posedge Clock) begin
    if (LoadEn && state_q == S_IDLE) mem_q[LoadAddr] <= LoadData;
  end

  assign ir       = mem_q[pc_q];
  assign imm_addr = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign step     = is_mvi_q ? 2'd2 : 2'd1;
  assign next_pc  = {1'b0, pc_q} + {{(ADDR_W-1){1'b0}}, step};
  assign wdog_inc = wdog_q + {{(WD_W-1){1'b0}}, 1'b1};

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      is_mvi_q   <= 1'b0;
      wdog_q     <= '0;
      finished_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      is_mvi_q   <= is_mvi_d;
      wdog_q     <= wdog_d;
      finished_q <= finished_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    is_mvi_d   = is_mvi_q;
    wdog_d     = wdog_q;
    finished_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          if (ProgLen != '0) begin
            pc_d    = '0;
            state_d = S_ISSUE;
          end else begin
            finished_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        is_mvi_d = (ir[8:6] == 3'b001);
        wdog_d   = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        wdog_d = wdog_inc;
        // Done in the final watchdog cycle still wins over the timeout.
        if (Done) begin
          if (next_pc >= ProgLen) begin
            state_d    = S_IDLE;
            finished_d = 1'b1;
          end else begin
            pc_d    = next_pc[ADDR_W-1:0];
            state_d = S_ISSUE;
          end
        end else if (wdog_inc == WD_W'(TIMEOUT)) begin
          state_d = S_ERR;
        end
      end
      default: state_d = S_ERR;
    endcase
  end

  always_comb begin
    DIN = '0;
    case (state_q)
      S_ISSUE: DIN = ir;
      S_WAIT:  DIN = is_mvi_q ? mem_q[imm_addr] : ir;
      default: DIN = '0;
    endcase
  end

  assign Run      = (state_q == S_ISSUE);
  assign Busy     = (state_q != S_IDLE);
  assign Error    = (state_q == S_ERR);
  assign Finished = finished_q;
  assign PC       = pc_q;
  assign StateDbg = state_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench for prog_sequencer: directed programs push expected
// Run/immediate/Finished events; a monitor pops and compares them.
module tb_prog_sequencer;

  localparam int ADDR_W = 5;
  localparam logic [1:0] K_RUN = 2'd1, K_IMM = 2'd2, K_FIN = 2'd3;

  logic              Clock = 1'b0;
  logic              Reset, Start, LoadEn, Done;
  logic [ADDR_W:0]   ProgLen;
  logic [ADDR_W-1:0] LoadAddr;
  logic [8:0]        LoadData;
  logic [8:0]        DIN;
  logic              Run, Busy, Finished, Error;
  logic [ADDR_W-1:0] PC;
  logic [1:0]        StateDbg;

  int checks = 0;
  int errors = 0;

  // Event word: {kind, pc, din}
  logic [15:0] exp_q[$];

  logic proc_en   = 1'b0;
  logic proc_kill = 1'b0;
  int   done_delay = 1;
  int   cnt = 0;
  logic prev_mvi = 1'b0;

  prog_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(15)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .ProgLen(ProgLen),
    .LoadEn(LoadEn), .LoadAddr(LoadAddr), .LoadData(LoadData), .Done(Done),
    .DIN(DIN), .Run(Run), .PC(PC), .Busy(Busy), .Finished(Finished),
    .Error(Error), .StateDbg(StateDbg)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input logic [1:0] kind, input logic [4:0] pc, input logic [8:0] din);
    exp_q.push_back({kind, pc, din});
  endtask

  task automatic observe(input logic [15:0] obs);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got %0h expected none at %0t", obs, $time);
    end else begin
      e = exp_q.pop_front();
      check("event", {16'h0, obs}, {16'h0, e});
    end
  endtask

  // Monitor: Run pulses, the word after an mvi issue, and Finished pulses.
  always @(negedge Clock) begin
    if (Reset) begin
      prev_mvi = 1'b0;
    end else begin
      if (prev_mvi) observe({K_IMM, PC, DIN});
      prev_mvi = Run && (DIN[8:6] == 3'b001);
      if (Run) observe({K_RUN, PC, DIN});
      if (Finished) observe({K_FIN, PC, DIN});
    end
  end

  // Processor model: answers Done done_delay cycles after each Run.
  initial begin
    Done = 1'b0;
    forever begin
      @(negedge Clock);
      if (Done) begin
        check("next_after_done", {31'h0, Run | Finished}, 32'h1);
        Done = 1'b0;
      end
      if (proc_kill) cnt = 0;
      else if (Run && proc_en) cnt = done_delay;
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) Done = 1'b1;
      end
    end
  end

  task automatic load(input logic [4:0] a, input logic [8:0] d);
    LoadEn = 1'b1; LoadAddr = a; LoadData = d;
    @(negedge Clock);
    LoadEn = 1'b0;
  endtask

  task automatic start_prog(input logic [ADDR_W:0] len);
    ProgLen = len; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(negedge Clock);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    @(negedge Clock);
    check("busy_after_prog", {31'h0, Busy}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1'b1; Start = 1'b0; LoadEn = 1'b0; LoadAddr = '0; LoadData = '0; ProgLen = '0;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    check("rst_run", {31'h0, Run}, 0);
    check("rst_din", {23'h0, DIN}, 0);
    check("rst_busy", {31'h0, Busy}, 0);
    check("rst_fin", {31'h0, Finished}, 0);
    check("rst_err", {31'h0, Error}, 0);
    check("rst_pc", {27'h0, PC}, 0);

    // mvi with immediate
    load(5'd0, 9'h040); load(5'd1, 9'd5);
    proc_en = 1'b1; done_delay = 2;
    push_ev(K_RUN, 5'd0, 9'h040); push_ev(K_IMM, 5'd0, 9'd5); push_ev(K_FIN, 5'd0, 9'h0);
    start_prog(6'd2);
    wait_drain(50);

    // three 1-word instructions
    load(5'd0, 9'h081); load(5'd1, 9'h0C2); load(5'd2, 9'h008);
    done_delay = 3;
    push_ev(K_RUN, 5'd0, 9'h081); push_ev(K_RUN, 5'd1, 9'h0C2);
    push_ev(K_RUN, 5'd2, 9'h008); push_ev(K_FIN, 5'd2, 9'h0);
    start_prog(6'd3);
    wait_drain(60);

    // watchdog: no Done
    proc_en = 1'b0;
    push_ev(K_RUN, 5'd0, 9'h081);
    start_prog(6'd1);
    for (int i = 0; i < 15; i++) begin
      @(negedge Clock);
      check("err_early", {31'h0, Error}, 0);
    end
    @(negedge Clock);
    check("err_set", {31'h0, Error}, 1);
    check("err_busy", {31'h0, Busy}, 1);
    start_prog(6'd1);
    repeat (3) @(negedge Clock);
    check("err_sticky", {31'h0, Error}, 1);
    check("err_run", {31'h0, Run}, 0);
    check("err_din", {23'h0, DIN}, 0);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check("err_clear", {31'h0, Error}, 0);
    check("err_idle", {31'h0, Busy}, 0);

    // Done in the last watchdog cycle is accepted
    proc_en = 1'b1; done_delay = 15;
    push_ev(K_RUN, 5'd0, 9'h081); push_ev(K_FIN, 5'd0, 9'h0);
    start_prog(6'd1);
    wait_drain(40);
    check("late_done_noerr", {31'h0, Error}, 0);

    // reset during WAIT of the second instruction, then replay
    done_delay = 3;
    push_ev(K_RUN, 5'd0, 9'h081); push_ev(K_RUN, 5'd1, 9'h0C2);
    start_prog(6'd3);
    repeat (5) @(negedge Clock);
    Reset = 1'b1; proc_kill = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check("mid_rst_busy", {31'h0, Busy}, 0);
    check("mid_rst_pc", {27'h0, PC}, 0);
    check("mid_rst_run", {31'h0, Run}, 0);
    check("mid_rst_q", exp_q.size(), 0);
    repeat (3) @(negedge Clock);
    proc_kill = 1'b0;
    push_ev(K_RUN, 5'd0, 9'h081); push_ev(K_RUN, 5'd1, 9'h0C2);
    push_ev(K_RUN, 5'd2, 9'h008); push_ev(K_FIN, 5'd2, 9'h0);
    start_prog(6'd3);
    wait_drain(60);

    // loads while busy are ignored
    push_ev(K_RUN, 5'd0, 9'h081); push_ev(K_RUN, 5'd1, 9'h0C2);
    push_ev(K_RUN, 5'd2, 9'h008); push_ev(K_FIN, 5'd2, 9'h0);
    start_prog(6'd3);
    for (int i = 0; i < 10; i++) begin
      LoadEn = 1'b1; LoadAddr = 5'(i % 3); LoadData = 9'h1FF;
      @(negedge Clock);
    end
    LoadEn = 1'b0;
    wait_drain(60);
    push_ev(K_FIN, 5'd2, 9'h0);
    start_prog(6'd0);
    wait_drain(10);
    push_ev(K_RUN, 5'd0, 9'h081); push_ev(K_RUN, 5'd1, 9'h0C2);
    push_ev(K_RUN, 5'd2, 9'h008); push_ev(K_FIN, 5'd2, 9'h0);
    start_prog(6'd3);
    wait_drain(60);

    // mvi at last address wraps immediate to mem[0]
    for (int i = 3; i < 31; i++) load(5'(i), 9'(i));
    load(5'd31, 9'h040);
    done_delay = 1;
    push_ev(K_RUN, 5'd0, 9'h081); push_ev(K_RUN, 5'd1, 9'h0C2); push_ev(K_RUN, 5'd2, 9'h008);
    for (int i = 3; i < 31; i++) push_ev(K_RUN, 5'(i), 9'(i));
    push_ev(K_RUN, 5'd31, 9'h040); push_ev(K_IMM, 5'd31, 9'h081); push_ev(K_FIN, 5'd31, 9'h0);
    start_prog(6'd32);
    wait_drain(200);

    repeat (3) @(negedge Clock);
    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
